ic7402_tester: RTL



---
 rtl/ic7402_pkg.sv | 13 +
 rtl/ic7402_vec_gen.sv | 17 +
 rtl/ic7402_tester.sv | 108 ++++++++++
 3 files changed

// File: rtl/ic7402_pkg.sv
// ic7402_pkg: shared states, gate constants and NOR drive/expect helpers for the 7402 tester.
package ic7402_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  localparam int NUM_GATES = 4;
  localparam int NUM_VEC = 4;
  function automatic logic nor_expect(input logic a, input logic b);
    return ~(a | b);
  endfunction
  // Rotating per-gate code so neighbouring gates never see the same input pair.
  function automatic logic [1:0] gate_code(input logic [1:0] vec, input int g);
    return vec + 2'(g);
  endfunction
endpackage

// File: rtl/ic7402_vec_gen.sv
// ic7402_vec_gen: maps a vector index to the a/b drive words and the expected NOR outputs.
module ic7402_vec_gen
  import ic7402_pkg::*;
(
  input  logic [1:0] vec,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] exp
);
  for (genvar g = 0; g < NUM_GATES; g++) begin : gen_gate
    logic [1:0] c;
    assign c = gate_code(vec, g);
    assign a[g] = c[1];
    assign b[g] = c[0];
    assign exp[g] = nor_expect(c[1], c[0]);
  end
endmodule

// File: rtl/ic7402_tester.sv
// ic7402_tester: sequences drive/settle/check over all NOR input codes and accumulates a pass/fail verdict.
module ic7402_tester
  import ic7402_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             abort_in,
  output logic [3:0]       dut_a_out,
  output logic [3:0]       dut_b_out,
  input  logic [3:0]       dut_y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [3:0]       fail_mask_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [1:0]       vec_idx_out
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  localparam int EW = ERR_W + 3;
  state_t state, state_nx;
  logic [SW-1:0] settle;
  logic [PW-1:0] pass_cnt;
  logic [3:0] a_nx, b_nx, exp, mis;
  logic [EW-1:0] err_sum;
  logic [ERR_W-1:0] err_nx;
  logic last;
  ic7402_vec_gen u_vec_gen (
    .vec(vec_idx_out),
    .a  (a_nx),
    .b  (b_nx),
    .exp(exp)
  );
  assign busy_out = state != IDLE;
  assign mis = dut_y_in ^ exp;
  assign err_sum = EW'(err_count_out) + EW'($countones(mis));
  assign err_nx = err_sum > EW'({ERR_W{1'b1}}) ? '1 : err_sum[ERR_W-1:0];
  assign last = vec_idx_out == 2'd3 && pass_cnt == PW'(NUM_PASSES - 1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = (start_in && !abort_in) ? DRIVE : IDLE;
      DRIVE:   state_nx = abort_in ? IDLE : (SETTLE_CYCLES == 0 ? CHECK : SETTLE);
      SETTLE:  state_nx = abort_in ? IDLE : (settle == SW'(1) ? CHECK : SETTLE);
      CHECK:   state_nx = abort_in ? IDLE : (last ? DONE : DRIVE);
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      settle        <= '0;
      pass_cnt      <= '0;
      vec_idx_out   <= '0;
      dut_a_out     <= '0;
      dut_b_out     <= '0;
      done_out      <= 1'b0;
      pass_out      <= 1'b0;
      fail_mask_out <= '0;
      err_count_out <= '0;
    end else begin
      state    <= state_nx;
      done_out <= 1'b0;
      unique case (state)
        IDLE: if (start_in && !abort_in) begin
          fail_mask_out <= '0;
          err_count_out <= '0;
          vec_idx_out   <= '0;
          pass_cnt      <= '0;
          pass_out      <= 1'b0;
        end
        DRIVE: begin
          dut_a_out <= a_nx;
          dut_b_out <= b_nx;
          settle    <= SW'(SETTLE_CYCLES);
        end
        SETTLE: settle <= settle - SW'(1);
        CHECK: begin
          fail_mask_out <= fail_mask_out | mis;
          err_count_out <= err_nx;
          if (!last) begin
            vec_idx_out <= vec_idx_out + 2'd1;
            if (vec_idx_out == 2'd3) pass_cnt <= pass_cnt + PW'(1);
          end else begin
            done_out  <= 1'b1;
            pass_out  <= (fail_mask_out | mis) == 4'd0;
            dut_a_out <= '0;
            dut_b_out <= '0;
          end
        end
        default: ;
      endcase
      // Abort wins over anything decided above, but the CHECK accumulation is kept.
      if (abort_in && state != IDLE) begin
        dut_a_out <= '0;
        dut_b_out <= '0;
        done_out  <= 1'b0;
        pass_out  <= 1'b0;
      end
    end
  end
endmodule
